// File: rtl/dfdd_pkg.sv
// dfdd_pkg: shared types, constants and helpers for the dfdd pipeline
package dfdd_pkg;
  localparam int MAX_SCALE = 2;
  typedef logic [1:0] scale_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} zis_state_e;
  function automatic int fp_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: raster col/row walker over a W x H frame, wrapping to (0,0) after the last pixel
//  clk_i, rst_ni : clock, async active-low reset
//  en            : advance one pixel
//  clr           : synchronous return to (0,0), wins over en
//  col, row      : current coordinate
//  last          : current coordinate is the final pixel of the frame
module raster_counter #(
  parameter int W = 64,
  parameter int H = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic        last
);
  logic col_end, row_end;
  assign col_end = col == 16'(W - 1);
  assign row_end = row == 16'(H - 1);
  assign last = col_end && row_end;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      col <= col_end ? '0 : col + 16'd1;
      row <= col_end ? (row_end ? '0 : row + 16'd1) : row;
    end
  end
endmodule

// File: rtl/zero_insert_scheduler.sv
// zero_insert_scheduler: multi-scale zero-insertion sequencer, pops coarse samples on the scale grid and emits +0.0 elsewhere
//  clk_i, rst_ni            : clock, async active-low reset
//  start_i, abort_i         : start a frame (IDLE only) / return to IDLE immediately
//  cfg_scale_i              : first scale of the frame, 3 treated as 2
//  src_data/valid/ready     : coarse sample stream in
//  dst_data/col/row/valid/ready : upsampled stream out with its raster coordinate
//  scale_o, busy_o, done_o  : scale of the beat in the output register, frame active, frame complete pulse
module zero_insert_scheduler
  import dfdd_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  localparam int FP_WIDTH  = fp_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          cfg_scale_i,
  input  logic [FP_WIDTH-1:0] src_data_i,
  input  logic                src_valid_i,
  output logic                src_ready_o,
  output logic [FP_WIDTH-1:0] dst_data_o,
  output logic [15:0]         dst_col_o,
  output logic [15:0]         dst_row_o,
  output logic                dst_valid_o,
  input  logic                dst_ready_i,
  output logic [1:0]          scale_o,
  output logic                busy_o,
  output logic                done_o
);
  if ((IMG_WIDTH % 8) != 0 || IMG_WIDTH <= 0 || IMG_WIDTH > 65535) begin : g_bad_width
    $error("IMG_WIDTH must be a positive multiple of 8 no larger than 65535");
  end
  if ((IMG_HEIGHT % 8) != 0 || IMG_HEIGHT <= 0 || IMG_HEIGHT > 65535) begin : g_bad_height
    $error("IMG_HEIGHT must be a positive multiple of 8 no larger than 65535");
  end
  zis_state_e state_q, state_d;
  scale_t s_q;
  logic [15:0] col, row, mask;
  logic last, keep, adv, fire, start, accept;
  assign start = state_q == IDLE && start_i;
  assign accept = dst_valid_o && dst_ready_i;
  assign mask = (16'd2 << s_q) - 16'd1;
  assign keep = ((row & mask) == '0) && ((col & mask) == '0);
  assign adv = !dst_valid_o || dst_ready_i;
  // abort suppresses the pop as well, so a sample is never consumed without being emitted
  assign fire = state_q == RUN && adv && (!keep || src_valid_i) && !abort_i;
  raster_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT)) u_raster (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (fire),
    .clr   (abort_i || state_q == IDLE),
    .col   (col),
    .row   (row),
    .last  (last)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (abort_i) state_d = IDLE;
    else if (start) state_d = RUN;
    else if (state_q == RUN && fire && last && s_q == '0) state_d = DRAIN;
    else if (state_q == DRAIN && accept) state_d = IDLE;
  end
  always_comb begin
    busy_o = state_q != IDLE;
    src_ready_o = state_q == RUN && keep && adv && !abort_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q         <= '0;
      dst_data_o  <= '0;
      dst_col_o   <= '0;
      dst_row_o   <= '0;
      dst_valid_o <= 1'b0;
      scale_o     <= '0;
      done_o      <= 1'b0;
    end else if (abort_i) begin
      s_q         <= '0;
      dst_data_o  <= '0;
      dst_col_o   <= '0;
      dst_row_o   <= '0;
      dst_valid_o <= 1'b0;
      scale_o     <= '0;
      done_o      <= 1'b0;
    end else begin
      if (start) s_q <= cfg_scale_i > scale_t'(MAX_SCALE) ? scale_t'(MAX_SCALE) : cfg_scale_i;
      else if (fire && last && s_q != '0) s_q <= s_q - 2'd1;
      if (fire) begin
        dst_data_o  <= keep ? src_data_i : '0;
        dst_col_o   <= col;
        dst_row_o   <= row;
        dst_valid_o <= 1'b1;
        scale_o     <= s_q;
      end else if (dst_ready_i) dst_valid_o <= 1'b0;
      done_o <= state_q == DRAIN && accept;
    end
  end
endmodule

// File: tb/tb_zero_insert_scheduler.sv
// tb_zero_insert_scheduler: scoreboard bench for zero_insert_scheduler at 8x8, FP32
module tb_zero_insert_scheduler;
  localparam int W = 8;
  localparam int H = 8;
  localparam logic [31:0] BASE = 32'h3F80_0000;
  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
    logic [15:0] r;
    logic [1:0]  s;
  } beat_t;
  logic        clk_i, rst_ni, start_i, abort_i, src_valid_i, src_ready_o;
  logic        dst_valid_o, dst_ready_i, busy_o, done_o;
  logic [1:0]  cfg_scale_i, scale_o;
  logic [31:0] src_data_i, dst_data_o;
  logic [15:0] dst_col_o, dst_row_o;
  beat_t exp_q[$];
  int checks = 0, errors = 0, hs_cnt = 0, pops = 0, pop0 = 0;
  bit exp_done = 0;
  assign src_data_i = BASE + 32'(pops - pop0);
  zero_insert_scheduler #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .cfg_scale_i(cfg_scale_i), .src_data_i(src_data_i), .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o), .dst_data_o(dst_data_o), .dst_col_o(dst_col_o),
    .dst_row_o(dst_row_o), .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
    .scale_o(scale_o), .busy_o(busy_o), .done_o(done_o)
  );
  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_i) begin
    if (exp_done) begin
      chk("done_pulse", {done_o, busy_o}, 72'b10);
      exp_done = 0;
    end else if (done_o) chk("spurious_done", 72'(done_o), 72'd0);
    if (dst_valid_o && dst_ready_i) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("unexpected_beat", 72'(dst_valid_o), 72'd0);
      else begin
        chk("beat", 72'({dst_data_o, dst_col_o, dst_row_o, scale_o}), 72'(exp_q.pop_front()));
        if (exp_q.size() == 0) exp_done = 1;
      end
    end
  end
  always @(negedge clk_i) if (src_valid_i && src_ready_o) begin
    @(posedge clk_i);
    #1 pops++;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic push_frame(input logic [1:0] cfg);
    int k = 0;
    int s0 = cfg > 2 ? 2 : int'(cfg);
    for (int s = s0; s >= 0; s--)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          int m = (2 << s) - 1;
          bit kp = ((r & m) == 0) && ((c & m) == 0);
          exp_q.push_back('{d: kp ? BASE + 32'(k) : 32'd0, c: 16'(c), r: 16'(r), s: 2'(s)});
          if (kp) k++;
        end
  endtask
  task automatic start_frame(input logic [1:0] cfg, output int b0);
    pop0 = pops;
    b0 = hs_cnt;
    push_frame(cfg);
    cfg_scale_i = cfg;
    start_i = 1;
    cyc(1);
    start_i = 0;
    cfg_scale_i = 2'd0;
  endtask
  task automatic wait_beats(input int n);
    int t = 0;
    while (hs_cnt < n && t < 2000) begin
      cyc(1);
      t++;
    end
    if (hs_cnt < n) chk("beat_timeout", 72'(hs_cnt), 72'(n));
  endtask
  task automatic finish_frame(input int b0, input int nbeats, input int npops);
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 2000) begin
      cyc(1);
      t++;
    end
    if (t >= 2000) begin
      chk("frame_timeout", 72'(exp_q.size()), 72'd0);
      exp_q.delete();
    end
    cyc(2);
    chk("beats", 72'(hs_cnt - b0), 72'(nbeats));
    chk("pops", 72'(pops - pop0), 72'(npops));
  endtask
  task automatic chk_idle(input string name);
    chk(name, 72'({dst_valid_o, busy_o, done_o, src_ready_o, scale_o, dst_col_o, dst_row_o, dst_data_o}), 72'd0);
  endtask
  initial begin
    int b0;
    rst_ni = 0; start_i = 0; abort_i = 0; cfg_scale_i = 0; src_valid_i = 1; dst_ready_i = 1;
    cyc(3);
    chk_idle("reset_state");
    rst_ni = 1;
    cyc(1);
    chk_idle("after_reset");
    start_frame(2'd0, b0);
    finish_frame(b0, 64, 16);
    start_frame(2'd2, b0);
    finish_frame(b0, 192, 21);
    start_frame(2'd0, b0);
    wait_beats(b0 + 10);
    dst_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_hold", 72'({dst_valid_o, src_ready_o, dst_col_o, dst_row_o, dst_data_o}), {2'b10, 16'd2, 16'd1, 32'd0});
    end
    dst_ready_i = 1;
    finish_frame(b0, 64, 16);
    start_frame(2'd0, b0);
    wait_beats(b0 + 14);
    src_valid_i = 0;
    cyc(4);
    chk("src_stall", 72'({dst_valid_o, src_ready_o, busy_o}), 72'b011);
    src_valid_i = 1;
    finish_frame(b0, 64, 16);
    start_frame(2'd1, b0);
    wait_beats(b0 + 30);
    rst_ni = 0;
    #1 chk_idle("async_reset");
    exp_q.delete();
    cyc(2);
    rst_ni = 1;
    cyc(1);
    start_frame(2'd1, b0);
    wait_beats(b0 + 30);
    abort_i = 1;
    cyc(1);
    abort_i = 0;
    chk_idle("abort");
    exp_q.delete();
    cyc(3);
    chk_idle("abort_idle");
    start_frame(2'd2, b0);
    finish_frame(b0, 192, 21);
    start_frame(2'd3, b0);
    wait_beats(b0 + 50);
    start_i = 1;
    cyc(1);
    start_i = 0;
    finish_frame(b0, 192, 21);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
